cache_fill: RTL

- Read-side initiator for the 8-byte line cache block.
- Services halfword read requests from the bus front-end.
- On a hit, returns data straight from the cache block's line outputs.
- On a miss, it performs these steps:
  - invalidates and retargets the cache line;
  - issues a 4-beat SDRAM burst read;
  - streams the beats into the cache block via data_valid/cdata;
  - acknowledges the requester as soon as the wanted halfword lands (critical-word ack).
- Sits between the bus interface, the cache block and the SDRAM arbiter.

---
 rtl/cache_fill_pkg.sv | 36 +++
 rtl/cache_fill_timer.sv | 41 ++++
 rtl/cache_fill.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_pkg.sv
// Shared definitions for the cache line fill initiator: line geometry,
// fill state encoding and the reserved tag used to park the line on flush.
package cache_fill_pkg;

  localparam int ADDR_W     = 26;
  localparam int TAG_W      = 23;
  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;

  // Index of the last beat of a line burst.
  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  // Tag the cache block holds after reset; software never maps this line.
  localparam logic [TAG_W-1:0] FLUSH_TAG = 23'h555555;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INVAL = 2'd1,
    ST_REQ   = 2'd2,
    ST_FILL  = 2'd3
  } fill_state_e;

  // Select halfword idx out of a 64-bit line (halfword n at [16n+15:16n]).
  function automatic logic [WORD_W-1:0] line_word(input logic [63:0] line,
                                                  input logic [1:0]  idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cache_fill_timer.sv
// Fill watchdog: loaded while the line is being retargeted, counts down
// while the burst is requested or streaming, and flags expiry in the cycle
// the last allowed count is consumed. TIMEOUT of 0 never expires.
module cache_fill_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on retarget, otherwise decrement while running.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (run_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && run_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cache_fill.sv
// Read-side initiator for the 8-byte line cache: acks hits from the line
// outputs, and on a miss retargets the line, bursts four halfwords from
// SDRAM into the cache block and acks as soon as the wanted word is valid.
module cache_fill
  import cache_fill_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [WORD_W-1:0] rd_data,
  input  logic              flush,
  output logic              fill_err,
  input  logic [TAG_W-1:0]  cache_addr,
  input  logic [63:0]       cache_data1d,
  input  logic [3:0]        cache_valid,
  output logic              cache_invalid,
  output logic [ADDR_W-1:0] iaddr,
  output logic              data_valid,
  output logic [WORD_W-1:0] cdata,
  output logic              sd_req,
  output logic [TAG_W-1:0]  sd_addr,
  input  logic              sd_gnt,
  input  logic              sd_rvalid,
  input  logic [WORD_W-1:0] sd_rdata
);

  fill_state_e       state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic              rd_ack_q, rd_ack_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              cache_invalid_q, cache_invalid_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic              data_valid_q, data_valid_d;
  logic [WORD_W-1:0] cdata_q, cdata_d;
  logic              sd_req_q, sd_req_d;
  logic [TAG_W-1:0]  sd_addr_q, sd_addr_d;
  logic              fill_err_q, fill_err_d;

  logic tag_match_s, word_valid_s, lookup_st_s, hit_s, miss_s;
  logic flush_req_s, expire_s;

  cache_fill_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == ST_INVAL),
    .run_i   ((state_q == ST_REQ) || (state_q == ST_FILL)),
    .expire_o(expire_s)
  );

  // Hit/miss decode. The cycle after an ack is skipped so a held request is
  // not acked twice. While a retarget or a fill beat is still being absorbed
  // by the cache block its tag/valid outputs are stale, so no miss is raised
  // then (otherwise the word-3 critical ack would retarget the fresh line).
  always_comb begin
    tag_match_s  = (rd_addr[25:3] == cache_addr);
    word_valid_s = cache_valid[rd_addr[2:1]];
    lookup_st_s  = (state_q == ST_IDLE) || (state_q == ST_FILL);
    hit_s  = rd_req && tag_match_s && word_valid_s && lookup_st_s &&
             !rd_ack_q && !cache_invalid_q;
    miss_s = rd_req && !hit_s && (state_q == ST_IDLE) &&
             !rd_ack_q && !cache_invalid_q && !data_valid_q;
    flush_req_s = flush || flush_pend_q;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    flush_pend_d    = flush_pend_q || flush;
    rd_ack_d        = 1'b0;
    rd_data_d       = rd_data_q;
    cache_invalid_d = 1'b0;
    iaddr_d         = iaddr_q;
    data_valid_d    = 1'b0;
    cdata_d         = cdata_q;
    sd_addr_d       = sd_addr_q;
    fill_err_d      = fill_err_q;

    if (hit_s) begin
      rd_ack_d  = 1'b1;
      rd_data_d = line_word(cache_data1d, rd_addr[2:1]);
    end else begin
      rd_ack_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (flush_req_s) begin
          cache_invalid_d = 1'b1;
          iaddr_d         = {FLUSH_TAG, 3'b000};
          fill_err_d      = 1'b0;
          flush_pend_d    = 1'b0;
        end else if (miss_s) begin
          state_d         = ST_INVAL;
          cache_invalid_d = 1'b1;
          iaddr_d         = rd_addr;
          sd_addr_d       = rd_addr[25:3];
        end else begin
          state_d         = ST_IDLE;
        end
      end
      ST_INVAL: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (expire_s) begin
          state_d    = ST_IDLE;
          fill_err_d = 1'b1;
        end else if (sd_gnt) begin
          state_d = ST_FILL;
          if (sd_rvalid) begin
            data_valid_d = 1'b1;
            cdata_d      = sd_rdata;
            beat_d       = 2'd1;
          end else begin
            beat_d       = 2'd0;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_FILL: begin
        if (expire_s) begin
          state_d    = ST_IDLE;
          fill_err_d = 1'b1;
        end else if (sd_rvalid) begin
          data_valid_d = 1'b1;
          cdata_d      = sd_rdata;
          beat_d       = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    sd_req_d = (state_d == ST_REQ);
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      beat_q          <= 2'd0;
      flush_pend_q    <= 1'b0;
      rd_ack_q        <= 1'b0;
      rd_data_q       <= 16'h0000;
      cache_invalid_q <= 1'b0;
      iaddr_q         <= 26'h0000000;
      data_valid_q    <= 1'b0;
      cdata_q         <= 16'h0000;
      sd_req_q        <= 1'b0;
      sd_addr_q       <= 23'h000000;
      fill_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      flush_pend_q    <= flush_pend_d;
      rd_ack_q        <= rd_ack_d;
      rd_data_q       <= rd_data_d;
      cache_invalid_q <= cache_invalid_d;
      iaddr_q         <= iaddr_d;
      data_valid_q    <= data_valid_d;
      cdata_q         <= cdata_d;
      sd_req_q        <= sd_req_d;
      sd_addr_q       <= sd_addr_d;
      fill_err_q      <= fill_err_d;
    end
  end

  assign rd_ack        = rd_ack_q;
  assign rd_data       = rd_data_q;
  assign cache_invalid = cache_invalid_q;
  assign iaddr         = iaddr_q;
  assign data_valid    = data_valid_q;
  assign cdata         = cdata_q;
  assign sd_req        = sd_req_q;
  assign sd_addr       = sd_addr_q;
  assign fill_err      = fill_err_q;

endmodule
